// File: rtl/fd_pipe_ctrl_pkg.sv
// fd_pipe_ctrl_pkg: flush cause codes, fence FSM states and defaults for the fe/de stall/flush controller
package fd_pipe_ctrl_pkg;
  localparam int DRAIN_DEPTH_DEF = 3;
  typedef enum logic [1:0] {FC_FENCE = 2'd0, FC_FET = 2'd1, FC_BP = 2'd2, FC_EXC = 2'd3} flush_cause_e;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} fence_state_e;
  function automatic flush_cause_e fc_max(input flush_cause_e a, input flush_cause_e b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/fd_pipe_ctrl_if.sv
// fd_pipe_ctrl_if: stall/flush request inputs and fe/de control outputs of the pipeline controller
interface fd_pipe_ctrl_if
  import fd_pipe_ctrl_pkg::*;
#(parameter int CNT_W = 32);
  logic de_stall, exe_stall, memacc_stall;
  logic exc_flush, bp_err, fet_flush_req, fence_req, sb_empty, de2ex_inst_valid;
  logic pipe_stall, fe_hold, fd_flush, fence_stall, de2ex_inst_valid_real;
  flush_cause_e flush_cause;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  modport master (
    output de_stall, exe_stall, memacc_stall, exc_flush, bp_err, fet_flush_req, fence_req, sb_empty, de2ex_inst_valid,
    input  pipe_stall, fe_hold, fd_flush, flush_cause, fence_stall, de2ex_inst_valid_real, stall_cycles, flush_count
  );
  modport slave (
    input  de_stall, exe_stall, memacc_stall, exc_flush, bp_err, fet_flush_req, fence_req, sb_empty, de2ex_inst_valid,
    output pipe_stall, fe_hold, fd_flush, flush_cause, fence_stall, de2ex_inst_valid_real, stall_cycles, flush_count
  );
endinterface

// File: rtl/fd_pipe_ctrl_fence_seq.sv
// fence_seq: FENCE drain sequencer; waits DRAIN_DEPTH unstalled cycles and an empty store buffer, then requests a flush
module fence_seq
  import fd_pipe_ctrl_pkg::*;
#(parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF) (
  input  logic clk,
  input  logic cpurst_n,
  input  logic stall,
  input  logic abort,
  input  logic fence_req,
  input  logic sb_empty,
  output logic fence_stall,
  output logic fence_flush_req
);
  fence_state_e state, state_nx;
  logic [3:0] cnt, cnt_nx, cnt_dec;
  logic start;
  // state and drain counter registers
  always_ff @(posedge clk or negedge cpurst_n)
    if (!cpurst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // next state; the FLUSH decision looks at the post-decrement count so DRAIN lasts exactly DRAIN_DEPTH free cycles
  always_comb begin
    start    = fence_req & ~stall & ~abort;
    cnt_dec  = (~stall && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (start) begin
        state_nx = DRAIN;
        cnt_nx   = 4'(DRAIN_DEPTH);
      end
      DRAIN: begin
        cnt_nx   = cnt_dec;
        state_nx = abort ? IDLE : (cnt_dec == 4'd0 && sb_empty) ? FLUSH : DRAIN;
      end
      FLUSH: state_nx = (abort || !stall) ? IDLE : FLUSH;
      default: state_nx = IDLE;
    endcase
    fence_stall     = (state == IDLE) ? start : 1'b1;
    fence_flush_req = (state == FLUSH);
  end
endmodule

// File: rtl/fd_pipe_ctrl.sv
// fd_pipe_ctrl: fe/de stall/flush controller; optional perf counters under FD_PIPE_CTRL_PERF_EN
module fd_pipe_ctrl
  import fd_pipe_ctrl_pkg::*;
#(parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF) (
  input logic clk,
  input logic cpurst_n,
  fd_pipe_ctrl_if.slave bus
);
  logic ext_v, pend_v, fence_fl;
  flush_cause_e ext_cause, pend_cause, eff_cause;
  assign bus.pipe_stall = bus.de_stall | bus.exe_stall | bus.memacc_stall;
  assign ext_v = bus.exc_flush | bus.bp_err | bus.fet_flush_req;
  assign ext_cause = bus.exc_flush ? FC_EXC : bus.bp_err ? FC_BP : bus.fet_flush_req ? FC_FET : FC_FENCE;
  assign eff_cause = fc_max(ext_cause, pend_cause);
  assign bus.fd_flush = (ext_v | pend_v | fence_fl) & ~bus.pipe_stall;
  assign bus.flush_cause = bus.fd_flush ? eff_cause : FC_FENCE;
  assign bus.fe_hold = bus.pipe_stall | (bus.fence_stall & ~bus.fd_flush);
  assign bus.de2ex_inst_valid_real = bus.de2ex_inst_valid & ~bus.pipe_stall;
  // hold the highest-priority external flush seen during a stall until the stall releases
  always_ff @(posedge clk or negedge cpurst_n)
    if (!cpurst_n) begin
      pend_v     <= 1'b0;
      pend_cause <= FC_FENCE;
    end else begin
      pend_v     <= bus.pipe_stall & (pend_v | ext_v);
      pend_cause <= bus.pipe_stall ? eff_cause : FC_FENCE;
    end
  fence_seq #(.DRAIN_DEPTH(DRAIN_DEPTH)) u_fence (
    .clk(clk), .cpurst_n(cpurst_n), .stall(bus.pipe_stall), .abort(ext_v | pend_v),
    .fence_req(bus.fence_req), .sb_empty(bus.sb_empty),
    .fence_stall(bus.fence_stall), .fence_flush_req(fence_fl)
  );
`ifdef FD_PIPE_CTRL_PERF_EN
  localparam int CW = $bits(bus.stall_cycles);
  logic [CW-1:0] stall_q, flush_q;
  // free-running wrap-around stall and flush event counters
  always_ff @(posedge clk or negedge cpurst_n)
    if (!cpurst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CW'(bus.pipe_stall);
      flush_q <= flush_q + CW'(bus.fd_flush);
    end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif
endmodule

// File: tb/tb_fd_pipe_ctrl.sv
// tb_fd_pipe_ctrl: directed-vector bench for fd_pipe_ctrl with hand-computed expectations
module tb_fd_pipe_ctrl;
  import fd_pipe_ctrl_pkg::*;
  logic clk = 1'b0;
  logic cpurst_n;
  int vec = 0;
  int mis = 0;
  fd_pipe_ctrl_if #(.CNT_W(32)) bus ();
  fd_pipe_ctrl #(.DRAIN_DEPTH(3)) dut (.clk(clk), .cpurst_n(cpurst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      mis++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic o(input string tag, input logic ff, input logic [1:0] fc, input logic fh, input logic fs);
    chk({tag, ".fd_flush"}, 32'(bus.fd_flush), 32'(ff));
    chk({tag, ".cause"}, 32'(bus.flush_cause), 32'(fc));
    chk({tag, ".fe_hold"}, 32'(bus.fe_hold), 32'(fh));
    chk({tag, ".fence_stall"}, 32'(bus.fence_stall), 32'(fs));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    cpurst_n = 1'b0;
    bus.de_stall = 0; bus.exe_stall = 0; bus.memacc_stall = 0;
    bus.exc_flush = 0; bus.bp_err = 0; bus.fet_flush_req = 0;
    bus.fence_req = 0; bus.sb_empty = 1; bus.de2ex_inst_valid = 0;
    #1;
    o("rst", 0, 0, 0, 0);
    chk("rst.pipe_stall", 32'(bus.pipe_stall), 0);
    chk("rst.stall_cycles", bus.stall_cycles, 0);
    chk("rst.flush_count", bus.flush_count, 0);
    bus.de_stall = 1; bus.de2ex_inst_valid = 1;
    #1;
    chk("rst.comb_stall", 32'(bus.pipe_stall), 1);
    chk("rst.comb_hold", 32'(bus.fe_hold), 1);
    chk("rst.valid_real_stalled", 32'(bus.de2ex_inst_valid_real), 0);
    bus.de_stall = 0;
    #1;
    chk("valid_real", 32'(bus.de2ex_inst_valid_real), 1);
    bus.de2ex_inst_valid = 0;
    tick();
    cpurst_n = 1'b1;
    tick();
    // bp_err with no stall flushes immediately
    bus.bp_err = 1; #1;
    o("bp", 1, 2, 0, 0);
    tick(); bus.bp_err = 0; #1;
    o("bp.after", 0, 0, 0, 0);
    // bp_err held pending across a 3-cycle execute stall
    bus.exe_stall = 1; bus.bp_err = 1; #1;
    o("stall.c1", 0, 0, 1, 0);
    tick(); bus.bp_err = 0; #1;
    o("stall.c2", 0, 0, 1, 0);
    tick(); #1;
    o("stall.c3", 0, 0, 1, 0);
    tick(); bus.exe_stall = 0; #1;
    o("stall.c4", 1, 2, 0, 0);
    tick(); #1;
    o("stall.c5", 0, 0, 0, 0);
    // pending fetch flush overwritten by exception, lower bp_err dropped
    bus.de_stall = 1; bus.fet_flush_req = 1; #1;
    o("prio.c1", 0, 0, 1, 0);
    tick(); bus.fet_flush_req = 0; bus.exc_flush = 1; #1;
    o("prio.c2", 0, 0, 1, 0);
    tick(); bus.exc_flush = 0; bus.bp_err = 1; #1;
    o("prio.c3", 0, 0, 1, 0);
    tick(); bus.bp_err = 0; bus.de_stall = 0; #1;
    o("prio.rel", 1, 3, 0, 0);
    tick(); #1;
    o("prio.after", 0, 0, 0, 0);
    // emit-cycle collision: pending fetch, bp_err arrives on release
    bus.memacc_stall = 1; bus.fet_flush_req = 1;
    tick(); bus.fet_flush_req = 0; bus.memacc_stall = 0; bus.bp_err = 1; #1;
    o("emit.coll", 1, 2, 0, 0);
    tick(); bus.bp_err = 0; #1;
    o("emit.once", 0, 0, 0, 0);
    // fence with no stalls: fence_stall cycles 1-5, flush at 5, idle at 6
    bus.fence_req = 1; #1;
    o("fence.c1", 0, 0, 1, 1);
    tick(); #1;
    o("fence.c2", 0, 0, 1, 1);
    tick(); #1;
    o("fence.c3", 0, 0, 1, 1);
    tick(); #1;
    o("fence.c4", 0, 0, 1, 1);
    tick(); bus.fence_req = 0; #1;
    o("fence.c5", 1, 0, 0, 1);
    tick(); #1;
    o("fence.c6", 0, 0, 0, 0);
    // fence flush held while stalled in FLUSH
    bus.fence_req = 1;
    tick(); tick(); tick(); tick();
    bus.memacc_stall = 1; #1;
    o("fstall.c5", 0, 0, 1, 1);
    tick(); #1;
    o("fstall.c6", 0, 0, 1, 1);
    bus.memacc_stall = 0; bus.fence_req = 0; #1;
    o("fstall.rel", 1, 0, 0, 1);
    tick(); #1;
    o("fstall.idle", 0, 0, 0, 0);
    // store buffer never drains: stays in DRAIN until an exception aborts
    bus.sb_empty = 0; bus.fence_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      o("sb.drain", 0, 0, 1, 1);
    end
    bus.exc_flush = 1; bus.fence_req = 0; #1;
    o("sb.abort", 1, 3, 0, 1);
    tick(); bus.exc_flush = 0; bus.sb_empty = 1; #1;
    o("sb.idle", 0, 0, 0, 0);
    // async reset mid-DRAIN drops fence_stall immediately
    bus.fence_req = 1;
    tick(); bus.fence_req = 0; #1;
    o("rdrain.pre", 0, 0, 1, 1);
    cpurst_n = 1'b0; #1;
    o("rdrain.rst", 0, 0, 0, 0);
    tick(); cpurst_n = 1'b1;
    // async reset clears a pending flush
    bus.fence_req = 1;
    tick(); bus.de_stall = 1; bus.bp_err = 1; #1;
    o("rpend.c2", 0, 0, 1, 1);
    tick(); bus.bp_err = 0; #1;
    cpurst_n = 1'b0; bus.de_stall = 0; bus.fence_req = 0; #1;
    o("rpend.rst", 0, 0, 0, 0);
    chk("rpend.stall_cycles", bus.stall_cycles, 0);
    chk("rpend.flush_count", bus.flush_count, 0);
    tick(); cpurst_n = 1'b1;
    tick(); #1;
    o("rpend.after", 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
